// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATOS   = 3'd1,
    PARIDAD = 3'd2,
    PARADA  = 3'd3,
    VALIDAR = 3'd4
  } estado_t;

  localparam logic [7:0] PS2_RUPTURA    = 8'hF0;
  localparam logic [7:0] PS2_EXTENDIDO  = 8'hE0;
  localparam int         PS2_BITS_TRAMA = 11;

  // Odd parity: data plus parity bit must carry an odd number of ones.
  function automatic logic paridad_impar_ok(input logic [7:0] dato, input logic paridad);
    return ^{dato, paridad};
  endfunction

endpackage

// File: rtl/filtro_ps2.sv
// PS/2 front end: 2-FF synchronizers, clock glitch filter, falling-edge strobe.
// Latency: flanco_o fires 2 + FILTRO_CICLOS cycles after the raw clock falls.
// Backpressure: none; the strobe is a free-running one-cycle pulse.
//
// Ports:
//   clk_i, rst_n_i  system clock, async active-low reset
//   ps2_clk_i       raw PS/2 clock (asynchronous)
//   ps2_data_i      raw PS/2 data (asynchronous)
//   flanco_o        one-cycle strobe on each falling edge of the filtered clock
//   dato_sinc_o     synchronized PS/2 data, to be sampled on flanco_o
module filtro_ps2 #(
  parameter int FILTRO_CICLOS = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic flanco_o,
  output logic dato_sinc_o
);

  localparam int CW = (FILTRO_CICLOS > 1) ? $clog2(FILTRO_CICLOS + 1) : 1;

  logic [1:0]    r_clk_sinc;
  logic [1:0]    r_dato_sinc;
  logic          r_clk_filt;
  logic [CW-1:0] r_cnt;
  logic          r_flanco;

  // Synchronizers and the filtered level reset high (idle bus level) so that
  // leaving reset never produces a spurious falling edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_clk_sinc  <= 2'b11;
      r_dato_sinc <= 2'b11;
      r_clk_filt  <= 1'b1;
      r_cnt       <= '0;
      r_flanco    <= 1'b0;
    end else begin
      r_clk_sinc  <= {r_clk_sinc[0], ps2_clk_i};
      r_dato_sinc <= {r_dato_sinc[0], ps2_data_i};
      r_flanco    <= 1'b0;
      // Count consecutive samples that disagree with the filtered level; any
      // agreeing sample restarts the count, so short glitches are swallowed.
      if (r_clk_sinc[1] == r_clk_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTRO_CICLOS - 1)) begin
        r_cnt      <= '0;
        r_clk_filt <= r_clk_sinc[1];
        r_flanco   <= r_clk_filt;  // only a 1 -> 0 transition strobes
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign flanco_o    = r_flanco;
  assign dato_sinc_o = r_dato_sinc[1];

endmodule

// File: rtl/receptor_ps2.sv
// PS/2 keyboard receiver: frames bytes, strips break codes, tags E0 keys, holds make codes.
// Latency: nueva_tecla_o rises 2 cycles after the stop-bit strobe.
// Backpressure: none on the PS/2 side; an unread code is overwritten and desborde_o is set.
//
// Ports:
//   clk_i, rst_n_i           system clock, async active-low reset
//   ps2_clk_i, ps2_data_i    raw PS/2 lines
//   leer_i                   one-cycle acknowledge from the consumer
//   tecla_o                  last accepted make scan code
//   extendido_o              tecla_o was preceded by E0
//   nueva_tecla_o            an unread code is held
//   desborde_o               sticky: a code was overwritten before being read
//   error_o                  one-cycle pulse on start/parity/stop/timeout error
module receptor_ps2
  import ps2_pkg::*;
#(
  parameter int FILTRO_CICLOS  = 8,
  parameter int TIMEOUT_CICLOS = 20000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       leer_i,
  output logic [7:0] tecla_o,
  output logic       extendido_o,
  output logic       nueva_tecla_o,
  output logic       desborde_o,
  output logic       error_o
);

  localparam int          TW         = $clog2(TIMEOUT_CICLOS + 1);
  localparam int          BITS_DATOS = PS2_BITS_TRAMA - 3;  // minus start, parity, stop
  localparam logic [2:0]  ULTIMO_BIT = 3'(BITS_DATOS - 1);

  logic          w_flanco;
  logic          w_dato;

  estado_t       r_estado;
  estado_t       w_estado_sig;

  logic [2:0]    r_cnt_bits;
  logic [7:0]    r_shift;
  logic          r_paridad;
  logic          r_parada;
  logic [TW-1:0] r_cnt_to;
  logic          r_ruptura;
  logic          r_ext;

  logic [7:0]    r_tecla;
  logic          r_extendido;
  logic          r_nueva;
  logic          r_desborde;
  logic          r_error;

  logic          w_en_trama;
  logic          w_timeout;
  logic          w_trama_ok;
  logic          w_validar;
  logic          w_aceptar;
  logic          w_error;

  filtro_ps2 #(
    .FILTRO_CICLOS(FILTRO_CICLOS)
  ) u_filtro (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .flanco_o    (w_flanco),
    .dato_sinc_o (w_dato)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_estado <= IDLE;
    else          r_estado <= w_estado_sig;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_estado_sig = r_estado;
    unique case (r_estado)
      IDLE:    if (w_flanco && !w_dato) w_estado_sig = DATOS;
      DATOS: begin
        if (w_timeout)                                   w_estado_sig = IDLE;
        else if (w_flanco && (r_cnt_bits == ULTIMO_BIT)) w_estado_sig = PARIDAD;
      end
      PARIDAD: begin
        if (w_timeout)     w_estado_sig = IDLE;
        else if (w_flanco) w_estado_sig = PARADA;
      end
      PARADA: begin
        if (w_timeout)     w_estado_sig = IDLE;
        else if (w_flanco) w_estado_sig = VALIDAR;
      end
      VALIDAR: w_estado_sig = IDLE;
      default: w_estado_sig = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs / decode
  always_comb begin
    w_en_trama = (r_estado == DATOS) || (r_estado == PARIDAD) || (r_estado == PARADA);
    // A strobe arriving on the expiry cycle still counts as a live bus.
    w_timeout  = w_en_trama && !w_flanco && (r_cnt_to == TW'(TIMEOUT_CICLOS));
    w_trama_ok = paridad_impar_ok(r_shift, r_paridad) && r_parada;
    w_validar  = (r_estado == VALIDAR);
    w_aceptar  = w_validar && w_trama_ok && !r_ruptura &&
                 (r_shift != PS2_RUPTURA) && (r_shift != PS2_EXTENDIDO);
    w_error    = ((r_estado == IDLE) && w_flanco && w_dato) ||
                 (w_validar && !w_trama_ok) ||
                 w_timeout;
  end

  // ---------------------------------------------------------------- frame datapath
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt_bits <= '0;
      r_shift    <= '0;
      r_paridad  <= 1'b0;
      r_parada   <= 1'b0;
      r_cnt_to   <= '0;
    end else begin
      // Counter wraps 7 -> 0 exactly on the last data strobe.
      if (r_estado == IDLE)                r_cnt_bits <= '0;
      else if (r_estado == DATOS && w_flanco) r_cnt_bits <= r_cnt_bits + 3'd1;

      if (w_flanco) begin
        unique case (r_estado)
          DATOS:   r_shift   <= {w_dato, r_shift[7:1]};  // LSB arrives first
          PARIDAD: r_paridad <= w_dato;
          PARADA:  r_parada  <= w_dato;
          default: ;
        endcase
      end

      // Saturating so it can never wrap back below the limit.
      if (!w_en_trama || w_flanco)             r_cnt_to <= '0;
      else if (r_cnt_to != TW'(TIMEOUT_CICLOS)) r_cnt_to <= r_cnt_to + 1'b1;
    end
  end

  // ---------------------------------------------------------------- prefix flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ruptura <= 1'b0;
      r_ext     <= 1'b0;
    end else if (w_timeout || (w_validar && !w_trama_ok)) begin
      r_ruptura <= 1'b0;
      r_ext     <= 1'b0;
    end else if (w_validar) begin
      if (r_shift == PS2_RUPTURA) begin
        r_ruptura <= 1'b1;
      end else if (r_shift == PS2_EXTENDIDO) begin
        r_ext <= 1'b1;
      end else if (r_ruptura) begin
        // Released key: drop the code and forget any E0 seen before F0.
        r_ruptura <= 1'b0;
        r_ext     <= 1'b0;
      end else begin
        r_ext <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- holding register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tecla     <= '0;
      r_extendido <= 1'b0;
      r_nueva     <= 1'b0;
      r_desborde  <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_error <= w_error;
      if (w_aceptar) begin
        r_tecla     <= r_shift;
        r_extendido <= r_ext;
        r_nueva     <= 1'b1;
        // A simultaneous read consumed the old code, so nothing was lost.
        r_desborde  <= r_nueva && !leer_i;
      end else if (leer_i) begin
        r_nueva    <= 1'b0;
        r_desborde <= 1'b0;
      end
    end
  end

  assign tecla_o       = r_tecla;
  assign extendido_o   = r_extendido;
  assign nueva_tecla_o = r_nueva;
  assign desborde_o    = r_desborde;
  assign error_o       = r_error;

endmodule

// File: tb/tb_receptor_ps2.sv
// Self-checking bench for receptor_ps2 with a scoreboard of expected make codes.
// Bit timing is scaled down (filter 4, timeout 200, bit period 40 cycles).
// Checks reset, make/break/extended, parity, timeout, start error, glitch, overrun, reset mid-frame.
module tb_receptor_ps2;

  localparam int FILT = 4;
  localparam int TO   = 200;
  localparam int HP   = 20;
  localparam int GAP  = 40;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       leer     = 1'b0;
  logic [7:0] tecla;
  logic       extendido;
  logic       nueva;
  logic       desborde;
  logic       error_s;

  int n_asserts = 0;
  int n_fail    = 0;
  int err_cnt   = 0;

  logic [8:0] q_exp[$];
  logic [8:0] mon_exp;
  bit         m_rup = 1'b0;
  bit         m_ext = 1'b0;
  logic       prev_nueva = 1'b0;
  logic [8:0] prev_out   = '0;

  receptor_ps2 #(
    .FILTRO_CICLOS  (FILT),
    .TIMEOUT_CICLOS (TO)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .leer_i        (leer),
    .tecla_o       (tecla),
    .extendido_o   (extendido),
    .nueva_tecla_o (nueva),
    .desborde_o    (desborde),
    .error_o       (error_s)
  );

  initial forever #5 clk = ~clk;

  // Monitor: counts error pulses and compares every newly presented code.
  always @(negedge clk) begin
    if (error_s === 1'b1) err_cnt++;
    if (nueva === 1'b1 && (prev_nueva !== 1'b1 || {extendido, tecla} !== prev_out)) begin
      n_asserts++;
      if (q_exp.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got code %h ext %b, required no new code", tecla, extendido);
      end else begin
        mon_exp = q_exp.pop_front();
        if ({extendido, tecla} !== mon_exp) begin
          n_fail++;
          $display("FAIL scoreboard_code: got code %h ext %b, required code %h ext %b",
                   tecla, extendido, mon_exp[7:0], mon_exp[8]);
        end
      end
    end
    prev_nueva = nueva;
    prev_out   = {extendido, tecla};
  end

  // Drives the first nbits of a frame: start, 8 data LSB first, odd parity, stop.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = (~^b) ^ bad_par;
    fr  = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2_data = fr[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  // Reference behaviour of the prefix logic; expected codes go in the scoreboard
  // before the frame is driven.
  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    if (bad_par) begin
      m_rup = 1'b0; m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_rup = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (m_rup) begin
      m_rup = 1'b0; m_ext = 1'b0;
    end else begin
      q_exp.push_back({m_ext, b});
      m_ext = 1'b0;
    end
    send_bits(b, bad_par, 11);
  endtask

  task automatic do_leer();
    @(negedge clk); leer = 1'b1;
    @(negedge clk); leer = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_asserts += 5;
    if (tecla !== 8'h00)   begin n_fail++; $display("FAIL reset_tecla: got %h, required 00", tecla); end
    if (extendido !== 1'b0) begin n_fail++; $display("FAIL reset_ext: got %b, required 0", extendido); end
    if (nueva !== 1'b0)    begin n_fail++; $display("FAIL reset_nueva: got %b, required 0", nueva); end
    if (desborde !== 1'b0) begin n_fail++; $display("FAIL reset_desborde: got %b, required 0", desborde); end
    if (error_s !== 1'b0)  begin n_fail++; $display("FAIL reset_error: got %b, required 0", error_s); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_asserts++;
    if (nueva !== 1'b0 || err_cnt !== 0) begin
      n_fail++; $display("FAIL reset_release: nueva %b errors %0d, required 0 and 0", nueva, err_cnt);
    end
  endtask

  task automatic test_make();
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0);
    n_asserts += 4;
    if (nueva !== 1'b1)    begin n_fail++; $display("FAIL make_nueva: got %b, required 1", nueva); end
    if (tecla !== 8'h1C)   begin n_fail++; $display("FAIL make_tecla: got %h, required 1C", tecla); end
    if (extendido !== 1'b0) begin n_fail++; $display("FAIL make_ext: got %b, required 0", extendido); end
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL make_error: got %0d pulses, required 0", err_cnt - e0); end
    do_leer();
    n_asserts++;
    if (nueva !== 1'b0) begin n_fail++; $display("FAIL make_leer: nueva %b, required 0", nueva); end
  endtask

  task automatic test_break();
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    n_asserts++;
    if (nueva !== 1'b0) begin n_fail++; $display("FAIL break_nueva: got %b, required 0", nueva); end
    send_frame(8'h33, 1'b0);
    n_asserts++;
    if (tecla !== 8'h33 || nueva !== 1'b1) begin
      n_fail++; $display("FAIL break_next: tecla %h nueva %b, required 33 and 1", tecla, nueva);
    end
    do_leer();
  endtask

  task automatic test_extended();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    n_asserts++;
    if (tecla !== 8'h75 || extendido !== 1'b1) begin
      n_fail++; $display("FAIL ext_set: tecla %h ext %b, required 75 and 1", tecla, extendido);
    end
    do_leer();
    send_frame(8'h6C, 1'b0);
    n_asserts++;
    if (tecla !== 8'h6C || extendido !== 1'b0) begin
      n_fail++; $display("FAIL ext_clear: tecla %h ext %b, required 6C and 0", tecla, extendido);
    end
    do_leer();
  endtask

  task automatic test_parity();
    int e0;
    e0 = err_cnt;
    send_frame(8'h5A, 1'b1);
    n_asserts += 2;
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL parity_error: got %0d pulses, required 1", err_cnt - e0); end
    if (nueva !== 1'b0)     begin n_fail++; $display("FAIL parity_nueva: got %b, required 0", nueva); end
    send_frame(8'h5A, 1'b0);
    n_asserts++;
    if (tecla !== 8'h5A) begin n_fail++; $display("FAIL parity_recover: got %h, required 5A", tecla); end
    do_leer();
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    send_bits(8'h6C, 1'b0, 6);
    repeat (TO + 100) @(negedge clk);
    m_rup = 1'b0; m_ext = 1'b0;
    n_asserts += 2;
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL timeout_error: got %0d pulses, required 1", err_cnt - e0); end
    if (nueva !== 1'b0)     begin n_fail++; $display("FAIL timeout_nueva: got %b, required 0", nueva); end
    send_frame(8'h6C, 1'b0);
    n_asserts++;
    if (tecla !== 8'h6C || nueva !== 1'b1) begin
      n_fail++; $display("FAIL timeout_recover: tecla %h nueva %b, required 6C and 1", tecla, nueva);
    end
    do_leer();
  endtask

  task automatic test_start_error();
    int e0;
    e0 = err_cnt;
    @(negedge clk); ps2_data = 1'b1;
    repeat (HP) @(negedge clk); ps2_clk = 1'b0;
    repeat (HP) @(negedge clk); ps2_clk = 1'b1;
    repeat (GAP) @(negedge clk);
    n_asserts++;
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL start_error: got %0d pulses, required 1", err_cnt - e0); end
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_cnt;
    @(negedge clk); ps2_data = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
    send_frame(8'h1C, 1'b0);
    n_asserts += 2;
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_error: got %0d pulses, required 0", err_cnt - e0); end
    if (tecla !== 8'h1C || nueva !== 1'b1) begin
      n_fail++; $display("FAIL glitch_frame: tecla %h nueva %b, required 1C and 1", tecla, nueva);
    end
    do_leer();
  endtask

  task automatic test_overrun();
    send_frame(8'h1C, 1'b0);
    send_frame(8'h32, 1'b0);
    n_asserts += 2;
    if (tecla !== 8'h32)   begin n_fail++; $display("FAIL overrun_tecla: got %h, required 32", tecla); end
    if (desborde !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b, required 1", desborde); end
    do_leer();
    n_asserts++;
    if (nueva !== 1'b0 || desborde !== 1'b0) begin
      n_fail++; $display("FAIL overrun_leer: nueva %b desborde %b, required 0 and 0", nueva, desborde);
    end
  endtask

  task automatic test_leer_idle();
    do_leer();
    n_asserts++;
    if (nueva !== 1'b0 || desborde !== 1'b0 || tecla !== 8'h32) begin
      n_fail++; $display("FAIL leer_idle: nueva %b desborde %b tecla %h, required 0 0 32", nueva, desborde, tecla);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    send_frame(8'h1C, 1'b0);
    e0 = err_cnt;
    send_bits(8'h55, 1'b0, 4);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_asserts++;
    if (nueva !== 1'b0 || tecla !== 8'h00) begin
      n_fail++; $display("FAIL midreset_clear: nueva %b tecla %h, required 0 and 00", nueva, tecla);
    end
    rst_n = 1'b1;
    m_rup = 1'b0; m_ext = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h24, 1'b0);
    n_asserts += 2;
    if (tecla !== 8'h24)    begin n_fail++; $display("FAIL midreset_tecla: got %h, required 24", tecla); end
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL midreset_error: got %0d pulses, required 0", err_cnt - e0); end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity();
    test_timeout();
    test_start_error();
    test_glitch();
    test_overrun();
    test_leer_idle();
    test_reset_mid();
    repeat (10) @(negedge clk);
    n_asserts++;
    if (q_exp.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d codes never presented, required 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/receptor_ps2.md
# receptor_ps2

Receives PS/2 keyboard frames on the raw PS/2 clock/data lines and delivers validated make scan codes to `deco_ascii`, which converts them to ASCII. Strips break sequences (F0 xx), flags extended keys (E0 prefix), and holds each scan code until the processor-side peripheral logic acknowledges it.

## Interface

- `FILTRO_CICLOS`, 8: number of consecutive equal samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CICLOS`, 20000: idle system cycles allowed between PS/2 falling edges inside a frame before the frame is aborted (200 µs at 100 MHz).

Ports:

- `clk_i`: input, 1 bit. System clock; the block uses a single clock.
- `rst_n_i`: input, 1 bit. Asynchronous, active-low reset.
- `ps2_clk_i`: input, 1 bit. Raw PS/2 clock, asynchronous to `clk_i`.
- `ps2_data_i`: input, 1 bit. Raw PS/2 data, asynchronous to `clk_i`.
- `leer_i`: input, 1 bit. Single-cycle acknowledge from the consumer. Clears `nueva_tecla_o` and `desborde_o`.
- `tecla_o`: output, 8 bits. Last accepted make scan code; this is `dato_i` of `deco_ascii`.
- `extendido_o`: output, 1 bit. Set when `tecla_o` was preceded by E0.
- `nueva_tecla_o`: output, 1 bit. Level signal: an unread scan code is held.
- `desborde_o`: output, 1 bit. Sticky flag: a scan code was overwritten before it was read.
- `error_o`: output, 1 bit. One-cycle pulse on a start, parity, stop or timeout error.

## Operation

Front end:
- `ps2_clk_i` and `ps2_data_i` each pass through a 2-FF synchronizer.
- The clock is then filtered: the filtered level changes only after `FILTRO_CICLOS` consecutive equal samples.
- A falling edge of the filtered clock produces a one-cycle `flanco` strobe. Data is sampled from synchronized data on that strobe.

Frame format: 11 bits.
- Start bit = 0.
- 8 data bits, LSB first.
- Odd parity bit (data plus parity has an odd number of ones).
- Stop bit = 1.

FSM (`ps2_pkg::estado_t`):
- `IDLE`: on `flanco`, if data = 0, go to `DATOS` with bit counter = 0. If data = 1, pulse `error_o` and stay in `IDLE`.
- `DATOS`: shift data in on each `flanco`. After the 8th bit, go to `PARIDAD`.
- `PARIDAD`: capture the parity bit on `flanco`, then go to `PARADA`.
- `PARADA`: capture the stop bit on `flanco`, then go to `VALIDAR`.
- `VALIDAR`: one cycle, evaluated as below, then go to `IDLE`.
  - Parity or stop bit bad: pulse `error_o`, clear the prefix flags.
  - Byte = F0: set `ruptura`.
  - Byte = E0: set `ext`.
  - Any other byte with `ruptura` = 1: discard it and clear both flags (key release).
  - Any other byte with `ruptura` = 0: accept it. Load `tecla_o`, set `extendido_o` = `ext`, set `nueva_tecla_o`, clear `ext`.

Timeout:
- The timeout counter runs in `DATOS`, `PARIDAD` and `PARADA`, and clears on each `flanco`.
- When it reaches `TIMEOUT_CICLOS`: pulse `error_o`, go to `IDLE`, clear the prefix flags.

Holding register:
- An accept while `nueva_tecla_o` = 1 and `leer_i` = 0 overwrites `tecla_o` and sets `desborde_o`.
- `leer_i` in the same cycle as an accept: the accept wins. `nueva_tecla_o` stays 1, `tecla_o` takes the new code, and `desborde_o` is cleared rather than set.
- `leer_i` with `nueva_tecla_o` = 0 has no effect.

## Timing

- Reset values: all outputs 0, FSM in `IDLE`, `ruptura` = `ext` = 0, all counters 0.
- `rst_n_i` low mid-frame aborts the frame immediately, with no error pulse.
- `flanco` latency: 2 cycles (synchronizer) plus `FILTRO_CICLOS` cycles after the raw clock falls.
- `nueva_tecla_o` rises on the cycle after `VALIDAR`, i.e. one cycle after the stop-bit `flanco` plus one registered stage.
- `tecla_o` and `extendido_o` change in the same cycle that `nueva_tecla_o` rises. They are stable while `nueva_tecla_o` = 1 unless an overrun occurs.
- `nueva_tecla_o` and `desborde_o` fall on the cycle after `leer_i` is sampled high.
- The timeout counter is $clog2(`TIMEOUT_CICLOS`+1) bits wide and saturates, so it never wraps.
- The bit counter is 3 bits wide and wraps only at the transition to `PARIDAD`.

## Structure

- `ps2_pkg` holds:
  - `estado_t` enum.
  - `PS2_RUPTURA` = 8'hF0.
  - `PS2_EXTENDIDO` = 8'hE0.
  - `PS2_BITS_TRAMA` = 11.
- Sub-module `filtro_ps2`: synchronizers, glitch filter and falling-edge strobe. Outputs `flanco_o` and `dato_sinc_o`.
- `receptor_ps2` contains the FSM, shift register, prefix flags and holding register.

## Test plan

Frames are driven at a 50 µs bit period.

- Frame 1C, parity 0 → `tecla_o` = 8'h1C, `nueva_tecla_o` = 1, `extendido_o` = 0, `error_o` never pulses.
- Frames F0 then 1C → `nueva_tecla_o` stays 0. A following frame 33 → `tecla_o` = 8'h33.
- Frames E0 then 75 → `tecla_o` = 8'h75, `extendido_o` = 1. A following 6C → `extendido_o` = 0.
- Frame 5A with parity flipped → one `error_o` pulse, `nueva_tecla_o` = 0. A following correct 5A → `tecla_o` = 8'h5A.
- Stop driving after 5 data bits, wait 250 µs → one `error_o` pulse. A following full frame 6C → `tecla_o` = 8'h6C.
- Overrun case:
  - Frames 1C then 32 with no `leer_i` → `tecla_o` = 8'h32, `desborde_o` = 1.
  - Pulse `leer_i` → both flags are 0 on the next cycle.
- Reset case: assert `rst_n_i` low mid-frame, then send frame 24 → `tecla_o` = 8'h24 with no error.
